// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory read master among NUM_REQ requesters.
// Optional read timeout is built in when MEM_ARB_TIMEOUT_EN is defined.
module mem_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          algorithm_clock,
  input  logic                          algorithm_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_error,
  output logic                          mem_read_enable,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          wait_request,
  input  logic                          mem_read_ready,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  output logic                          busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW-1:0]      LAST_IDX = GW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DATA = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [GW-1:0]         r_grant, w_grant_nxt;
  logic [GW-1:0]         r_last_grant, w_last_grant_nxt;
  logic [NUM_REQ-1:0]    r_req_ack, w_req_ack_nxt;
  logic [NUM_REQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
  logic                  r_mem_read_enable, w_mem_read_enable_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_busy;
  logic                  w_found;
  logic [GW-1:0]         w_pick;
  logic [ADDR_WIDTH-1:0] w_pick_addr;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_timer, w_timer_nxt;
  logic        r_rsp_error, w_rsp_error_nxt;
`endif

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    return GW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Round-robin search starting just after the previous winner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[rr_idx(r_last_grant, k)]) begin
        w_found = 1'b1;
        w_pick  = rr_idx(r_last_grant, k);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Address slice of the requester selected by the search.
  always_comb begin
    w_pick_addr = req_addr[ADDR_WIDTH-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_pick_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        w_pick_addr = w_pick_addr;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt           = r_state;
    w_grant_nxt           = r_grant;
    w_last_grant_nxt      = r_last_grant;
    w_req_ack_nxt         = '0;
    w_rsp_valid_nxt       = '0;
    w_rsp_data_nxt        = r_rsp_data;
    w_mem_read_enable_nxt = 1'b0;
    w_mem_addr_nxt        = r_mem_addr;
`ifdef MEM_ARB_TIMEOUT_EN
    w_timer_nxt           = r_timer;
    w_rsp_error_nxt       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt           = w_pick;
          w_last_grant_nxt      = w_pick;
          w_mem_addr_nxt        = w_pick_addr;
          w_req_ack_nxt         = ONE_HOT0 << w_pick;
          w_mem_read_enable_nxt = 1'b1;
          w_state_nxt           = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!wait_request) begin
          w_mem_read_enable_nxt = 1'b0;
          w_state_nxt           = S_WAIT_DATA;
`ifdef MEM_ARB_TIMEOUT_EN
          w_timer_nxt           = 16'd0;
`endif
        end else begin
          w_mem_read_enable_nxt = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (mem_read_ready) begin
          w_rsp_data_nxt  = mem_read_data;
          w_rsp_valid_nxt = ONE_HOT0 << r_grant;
          w_state_nxt     = S_IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // A ready on the terminal cycle wins over the timeout above.
        else if (r_timer == TMO_LAST) begin
          w_rsp_data_nxt  = '0;
          w_rsp_valid_nxt = ONE_HOT0 << r_grant;
          w_rsp_error_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
`else
        else begin
          w_state_nxt = S_WAIT_DATA;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge algorithm_clock or posedge algorithm_reset) begin
    if (algorithm_reset) begin
      r_state           <= S_IDLE;
      r_grant           <= '0;
      r_last_grant      <= LAST_IDX;
      r_req_ack         <= '0;
      r_rsp_valid       <= '0;
      r_rsp_data        <= '0;
      r_mem_read_enable <= 1'b0;
      r_mem_addr        <= '0;
      r_busy            <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_grant           <= w_grant_nxt;
      r_last_grant      <= w_last_grant_nxt;
      r_req_ack         <= w_req_ack_nxt;
      r_rsp_valid       <= w_rsp_valid_nxt;
      r_rsp_data        <= w_rsp_data_nxt;
      r_mem_read_enable <= w_mem_read_enable_nxt;
      r_mem_addr        <= w_mem_addr_nxt;
      r_busy            <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Read timeout counter and error flag.
  always_ff @(posedge algorithm_clock or posedge algorithm_reset) begin
    if (algorithm_reset) begin
      r_timer     <= 16'd0;
      r_rsp_error <= 1'b0;
    end else begin
      r_timer     <= w_timer_nxt;
      r_rsp_error <= w_rsp_error_nxt;
    end
  end

  assign rsp_error = r_rsp_error;
`else
  // TIMEOUT_CYCLES has no role without the timeout feature.
  if (TIMEOUT_CYCLES < 1) begin : g_no_timeout
  end

  assign rsp_error = 1'b0;
`endif

  assign req_ack         = r_req_ack;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign mem_read_enable = r_mem_read_enable;
  assign mem_addr        = r_mem_addr;
  assign busy            = r_busy;

endmodule
